// File: rtl/encrypt_host_frontend_pkg.sv
// Shared configuration package for the encrypt system: frontend FSM states
// and default FIFO depth.
package encrypt_config;

    localparam int unsigned FRONTEND_FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        CFG_COLLECT,
        CFG_DRAIN,
        CFG_WRITE
    } fe_state_t;

endpackage

// File: rtl/encrypt_host_frontend_fifo.sv
// Byte FIFO for the host frontend; head byte is read combinationally so the
// parent can register it on pop.
module frontend_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE     = 1;
    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + ONE;
            if (pop && !empty)
                rd_ptr <= rd_ptr + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign level = wr_ptr - rd_ptr;
    assign full  = (level == DEPTH_L);
    assign empty = (level == '0);

endmodule

// File: rtl/encrypt_host_frontend.sv
// Host byte-stream frontend: splits host bytes into FIFO-buffered plaintext
// and 32-bit config words, never letting a config write overtake earlier data.
module encrypt_host_frontend
    import encrypt_config::*;
#(
    parameter int unsigned FIFO_DEPTH = FRONTEND_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          host_valid,
    input  logic                          host_cmd,
    input  logic [7:0]                    host_byte,
    output logic                          host_ready,
    input  logic                          stall,
    output logic                          enable,
    output logic [7:0]                    data_in_encrypt,
    output logic                          cfg_wen,
    output logic [31:0]                   cfg_data_in,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    fe_state_t  state;
    logic [1:0] byte_cnt;
    logic       ready_int;
    logic       accept;
    logic       push;
    logic       pop;
    logic [7:0] fifo_dout;
    logic       fifo_full;
    logic       fifo_empty;

    always_comb begin
        ready_int = 1'b0;
        case (state)
            IDLE:        ready_int = !fifo_full;
            CFG_COLLECT: ready_int = 1'b1;
            default:     ready_int = 1'b0;
        endcase
    end

    // Gated by rst so the host sees not-ready for the whole reset window.
    assign host_ready = rst && ready_int;
    assign accept     = host_valid && host_ready;
    assign push       = accept && (state == IDLE) && !host_cmd;
    assign pop        = !fifo_empty && !stall;

    frontend_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (host_byte),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            byte_cnt        <= '0;
            enable          <= 1'b0;
            data_in_encrypt <= '0;
            cfg_wen         <= 1'b0;
            cfg_data_in     <= '0;
        end else begin
            enable  <= pop;
            if (pop)
                data_in_encrypt <= fifo_dout;
            cfg_wen <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && host_cmd) begin
                        cfg_data_in[31:24] <= host_byte;
                        byte_cnt           <= 2'd1;
                        state              <= CFG_COLLECT;
                    end
                end
                CFG_COLLECT: begin
                    if (accept) begin
                        case (byte_cnt)
                            2'd1:    cfg_data_in[23:16] <= host_byte;
                            2'd2:    cfg_data_in[15:8]  <= host_byte;
                            default: cfg_data_in[7:0]   <= host_byte;
                        endcase
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3)
                            state <= CFG_DRAIN;
                    end
                end
                CFG_DRAIN: begin
                    // Empty FIFO implies no pop, so enable is low during the write.
                    if (fifo_empty && !pop) begin
                        state   <= CFG_WRITE;
                        cfg_wen <= 1'b1;
                    end
                end
                CFG_WRITE: begin
                    state    <= IDLE;
                    byte_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encrypt_host_frontend.sv
// Directed bench for encrypt_host_frontend with hand-computed expectations.
module tb_encrypt_host_frontend;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        host_valid = 1'b0;
    logic        host_cmd = 1'b0;
    logic [7:0]  host_byte = '0;
    logic        host_ready;
    logic        stall = 1'b0;
    logic        enable;
    logic [7:0]  data_in_encrypt;
    logic        cfg_wen;
    logic [31:0] cfg_data_in;
    logic [3:0]  fifo_level;

    int n_checks = 0;
    int n_fail   = 0;
    int wen_cnt  = 0;
    int wen_q_size = -1;
    logic [7:0] out_q [$];

    always #5 clk = ~clk;

    encrypt_host_frontend #(.FIFO_DEPTH(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .host_valid      (host_valid),
        .host_cmd        (host_cmd),
        .host_byte       (host_byte),
        .host_ready      (host_ready),
        .stall           (stall),
        .enable          (enable),
        .data_in_encrypt (data_in_encrypt),
        .cfg_wen         (cfg_wen),
        .cfg_data_in     (cfg_data_in),
        .fifo_level      (fifo_level)
    );

    always @(negedge clk) begin
        if (enable === 1'b1)
            out_q.push_back(data_in_encrypt);
        if (cfg_wen === 1'b1) begin
            wen_cnt++;
            wen_q_size = out_q.size();
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic c, input logic [7:0] b);
        int t;
        host_valid = 1'b1;
        host_cmd   = c;
        host_byte  = b;
        t = 0;
        while (host_ready !== 1'b1 && t < 50) begin
            step();
            t++;
        end
        if (t >= 50)
            chk("send_timeout", 32'd0, 32'd1);
        step();
        host_valid = 1'b0;
        host_cmd   = 1'b0;
    endtask

    initial begin
        int lvl;
        int idx;
        int cyc;
        logic push_e;
        logic pop_e;

        // Reset state
        repeat (3) step();
        chk("rst_host_ready", {31'd0, host_ready}, 32'd0);
        chk("rst_enable", {31'd0, enable}, 32'd0);
        chk("rst_data", {24'd0, data_in_encrypt}, 32'h00);
        chk("rst_cfg_wen", {31'd0, cfg_wen}, 32'd0);
        chk("rst_cfg_data", cfg_data_in, 32'h0);
        chk("rst_level", {28'd0, fifo_level}, 32'd0);
        rst = 1'b1;
        step();
        chk("idle_ready", {31'd0, host_ready}, 32'd1);

        // Config word FAAFBA13, command flag only on first byte
        send(1'b1, 8'hFA);
        send(1'b0, 8'hAF);
        send(1'b0, 8'hBA);
        send(1'b0, 8'h13);
        chk("cfg1_drain_wen", {31'd0, cfg_wen}, 32'd0);
        chk("cfg1_drain_ready", {31'd0, host_ready}, 32'd0);
        step();
        chk("cfg1_wen", {31'd0, cfg_wen}, 32'd1);
        chk("cfg1_word", cfg_data_in, 32'hFAAFBA13);
        chk("cfg1_wen_enable", {31'd0, enable}, 32'd0);
        step();
        chk("cfg1_wen_low", {31'd0, cfg_wen}, 32'd0);
        chk("cfg1_ready_back", {31'd0, host_ready}, 32'd1);
        repeat (3) step();
        chk("cfg1_wen_count", wen_cnt, 32'd1);
        chk("cfg1_word_hold", cfg_data_in, 32'hFAAFBA13);

        // Back-to-back data with one-cycle latency
        out_q.delete();
        send(1'b0, 8'h11);
        chk("d_lat_enable0", {31'd0, enable}, 32'd0);
        chk("d_lat_level", {28'd0, fifo_level}, 32'd1);
        send(1'b0, 8'h22);
        chk("d_en1", {31'd0, enable}, 32'd1);
        chk("d_byte1", {24'd0, data_in_encrypt}, 32'h11);
        send(1'b0, 8'h33);
        chk("d_en2", {31'd0, enable}, 32'd1);
        chk("d_byte2", {24'd0, data_in_encrypt}, 32'h22);
        step();
        chk("d_en3", {31'd0, enable}, 32'd1);
        chk("d_byte3", {24'd0, data_in_encrypt}, 32'h33);
        step();
        chk("d_en_off", {31'd0, enable}, 32'd0);
        chk("d_hold", {24'd0, data_in_encrypt}, 32'h33);

        // Fill under stall, then release
        out_q.delete();
        stall = 1'b1;
        for (int i = 0; i < 8; i++)
            send(1'b0, 8'h80 + 8'(i));
        chk("full_level", {28'd0, fifo_level}, 32'd8);
        chk("full_ready", {31'd0, host_ready}, 32'd0);
        host_valid = 1'b1;
        host_cmd   = 1'b0;
        host_byte  = 8'h88;
        step();
        chk("full_level_hold", {28'd0, fifo_level}, 32'd8);
        chk("full_ready_hold", {31'd0, host_ready}, 32'd0);
        chk("full_enable", {31'd0, enable}, 32'd0);
        stall = 1'b0;
        step();
        chk("rel_ready", {31'd0, host_ready}, 32'd1);
        chk("rel_level", {28'd0, fifo_level}, 32'd7);
        chk("rel_enable", {31'd0, enable}, 32'd1);
        chk("rel_byte", {24'd0, data_in_encrypt}, 32'h80);
        step();
        chk("rel_push_pop_level", {28'd0, fifo_level}, 32'd7);
        host_valid = 1'b0;
        repeat (10) step();
        chk("rel_count", out_q.size(), 32'd9);
        for (int i = 0; i < 9; i++)
            chk("rel_order", {24'd0, (i < out_q.size()) ? out_q[i] : 8'hxx}, 32'h80 + i);

        // Config must wait for earlier data to drain
        out_q.delete();
        stall = 1'b1;
        send(1'b0, 8'h5A);
        send(1'b0, 8'hA5);
        send(1'b1, 8'h01);
        send(1'b0, 8'h02);
        send(1'b0, 8'h03);
        send(1'b0, 8'h04);
        chk("ord_level", {28'd0, fifo_level}, 32'd2);
        repeat (2) step();
        chk("ord_no_wen", wen_cnt, 32'd1);
        stall = 1'b0;
        step();
        chk("ord_pop1", {24'd0, data_in_encrypt}, 32'h5A);
        chk("ord_wen_a", {31'd0, cfg_wen}, 32'd0);
        step();
        chk("ord_pop2", {24'd0, data_in_encrypt}, 32'hA5);
        chk("ord_wen_b", {31'd0, cfg_wen}, 32'd0);
        step();
        chk("ord_wen", {31'd0, cfg_wen}, 32'd1);
        chk("ord_word", cfg_data_in, 32'h01020304);
        step();
        chk("ord_wen_count", wen_cnt, 32'd2);
        chk("ord_data_before_wen", wen_q_size, 32'd2);

        // Reset mid-collection discards partial word
        send(1'b1, 8'hAA);
        send(1'b0, 8'hBB);
        rst = 1'b0;
        #1;
        chk("prst_cfg_data", cfg_data_in, 32'h0);
        chk("prst_ready", {31'd0, host_ready}, 32'd0);
        repeat (2) step();
        rst = 1'b1;
        repeat (6) step();
        chk("prst_no_wen", wen_cnt, 32'd2);
        chk("prst_cfg_hold", cfg_data_in, 32'h0);
        send(1'b1, 8'h0A);
        send(1'b0, 8'h0B);
        send(1'b0, 8'h0C);
        send(1'b0, 8'h0D);
        step();
        chk("prst_wen", {31'd0, cfg_wen}, 32'd1);
        chk("prst_word", cfg_data_in, 32'h0A0B0C0D);
        step();
        chk("prst_wen_count", wen_cnt, 32'd3);

        // Stall toggling under continuous pushes
        out_q.delete();
        lvl = 0;
        idx = 0;
        cyc = 0;
        stall = 1'b0;
        while (idx < 20 && cyc < 100) begin
            host_valid = 1'b1;
            host_cmd   = 1'b0;
            host_byte  = 8'hC0 + 8'(idx);
            stall      = cyc[0];
            push_e = (lvl < 8);
            pop_e  = (lvl > 0) && !stall;
            chk("tog_ready", {31'd0, host_ready}, {31'd0, push_e});
            step();
            lvl = lvl + int'(push_e) - int'(pop_e);
            if (push_e)
                idx++;
            chk("tog_level", {28'd0, fifo_level}, lvl);
            cyc++;
        end
        if (cyc >= 100)
            chk("tog_timeout", 32'd0, 32'd1);
        host_valid = 1'b0;
        stall = 1'b0;
        repeat (12) step();
        chk("tog_level_end", {28'd0, fifo_level}, 32'd0);
        chk("tog_count", out_q.size(), 32'd20);
        for (int i = 0; i < 20; i++)
            chk("tog_order", {24'd0, (i < out_q.size()) ? out_q[i] : 8'hxx}, 32'hC0 + i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
